// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider: counts 0..CLK_DIV-1, ticks on the last count, sync clear.
module uart_rx_tick_gen #(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned W = $clog2(CLK_DIV);

    logic [W-1:0] r_div;
    logic         w_last;

    assign w_last = (r_div == W'(CLK_DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (i_clear || w_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + W'(1);
        end
    end

endmodule

// File: rtl/uart_receiver_ovs.sv
// Parametrised oversampling UART receiver with valid/ack output handshake.
// Define RX_MAJORITY_EN for 2-of-3 voting around the bit centre.
module uart_receiver_ovs
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CLK_DIV    = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 data_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned SC_W = $clog2(OVERSAMPLE);
    localparam int unsigned HALF = OVERSAMPLE / 2;
`ifdef RX_MAJORITY_EN
    localparam int unsigned DECIDE_SC = HALF + 1;
`else
    localparam int unsigned DECIDE_SC = HALF;
`endif

    rx_state_e            r_state, w_state_nx;
    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    logic [SC_W-1:0]      r_sc;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_par_mode;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_start;
    logic                 w_sample;
    logic                 w_bit;
    logic                 w_complete;
    logic                 w_par_en;

    assign w_rx_s   = r_sync[1];
    assign w_sample = w_tick && (r_sc == SC_W'(DECIDE_SC));
    assign w_par_en = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    assign busy     = (r_state != IDLE);

`ifdef RX_MAJORITY_EN
    logic [1:0] r_vote;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vote <= '1;
        end else if (w_tick && r_sc == SC_W'(HALF - 1)) begin
            r_vote[0] <= w_rx_s;
        end else if (w_tick && r_sc == SC_W'(HALF)) begin
            r_vote[1] <= w_rx_s;
        end
    end

    assign w_bit = maj3(r_vote[0], r_vote[1], w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    uart_rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (w_start),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rx_prev && !w_rx_s) begin
                    w_state_nx = START;
                    w_start    = 1'b1;
                end
            end
            START: begin
                if (w_sample) w_state_nx = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_sample && r_idx == 3'(DATA_BITS - 1))
                    w_state_nx = w_par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (w_sample) w_state_nx = STOP;
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is caught at once.
                if (w_sample && r_idx == 3'(STOP_BITS - 1)) begin
                    w_state_nx = IDLE;
                    w_complete = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync     <= '1;
            r_rx_prev  <= 1'b1;
            r_sc       <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_mode <= PAR_NONE;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], RxD};
            r_rx_prev <= w_rx_s;
            if (w_start) begin
                r_sc       <= '0;
                r_idx      <= '0;
                r_shift    <= '0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
                r_par_mode <= parity_mode;
            end else if (w_tick) begin
                r_sc <= (r_sc == SC_W'(OVERSAMPLE - 1)) ? '0 : r_sc + SC_W'(1);
            end
            if (w_sample) begin
                case (r_state)
                    DATA: begin
                        r_shift[r_idx] <= w_bit;
                        r_idx <= (r_idx == 3'(DATA_BITS - 1)) ? '0 : r_idx + 3'd1;
                    end
                    PARITY: r_perr <= (^r_shift) ^ w_bit ^ (r_par_mode == PAR_ODD);
                    STOP: begin
                        if (!w_bit) r_ferr <= 1'b1;
                        r_idx <= r_idx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_complete) begin
            data       <= r_shift;
            parity_err <= r_perr;
            frame_err  <= r_ferr | ~w_bit;
            overrun    <= valid & ~data_ack;
            valid      <= 1'b1;
        end else if (data_ack) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_receiver_ovs.sv
// Table-driven bench for uart_receiver_ovs with a scoreboard of expected characters.
module tb_uart_receiver_ovs;

    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RxD = 1'b1;
    logic [1:0] parity_mode = 2'b00;
    logic       data_ack = 1'b0;
    logic [7:0] data;
    logic       valid, parity_err, frame_err, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    typedef struct {
        logic [1:0] pm;
        logic [7:0] d;
        logic       par_en;
        logic       par_bit;
        logic       stop;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    logic prev_busy = 1'b0;

    uart_receiver_ovs #(
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .OVERSAMPLE (16),
        .CLK_DIV    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RxD         (RxD),
        .parity_mode (parity_mode),
        .data        (data),
        .valid       (valid),
        .data_ack    (data_ack),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Callers are always at a negedge on entry; glitch_bit < 0 means no glitch.
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic stop, input int glitch_bit);
        RxD = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            if (i == glitch_bit) begin
                idle(36);
                RxD = ~d[i];
                idle(1);
                RxD = d[i];
                idle(BIT_CLK - 37);
            end else begin
                idle(BIT_CLK);
            end
        end
        if (par_en) begin
            RxD = par_bit;
            idle(BIT_CLK);
        end
        RxD = stop;
        idle(BIT_CLK);
        RxD = 1'b1;
    endtask

    task automatic ack_and_check(input string name);
        check({name, "_valid_hi"}, 32'(valid), 32'd1);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        check({name, "_valid_lo"}, 32'(valid), 32'd0);
    endtask

    // Completion is the cycle busy drops while valid is high.
    always @(negedge clk) begin
        if (prev_busy && !busy && valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_char: got data %0h expected none", data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data",       32'(data),       32'(e.d));
                check("sb_parity_err", 32'(parity_err), 32'(e.pe));
                check("sb_frame_err",  32'(frame_err),  32'(e.fe));
                check("sb_overrun",    32'(overrun),    32'(e.ov));
            end
        end
        prev_busy = busy;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'b01, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'b00, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'b00, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{2'b11, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{2'b00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        idle(5);
        rst = 1'b1;
        idle(2);
        check("rst_data",       32'(data),       32'd0);
        check("rst_valid",      32'(valid),      32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        idle(20);

        for (int i = 0; i < 10; i++) begin
            parity_mode = vecs[i].pm;
            sb.push_back('{d: vecs[i].d, pe: vecs[i].exp_pe, fe: vecs[i].exp_fe, ov: 1'b0});
            send_frame(vecs[i].d, vecs[i].par_en, vecs[i].par_bit, vecs[i].stop, -1);
            idle(10);
            check($sformatf("vec%0d_seen", i), 32'(sb.size()), 32'd0);
            ack_and_check($sformatf("vec%0d", i));
            idle(20);
        end
        parity_mode = 2'b00;

        RxD = 1'b0;
        idle(10);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        idle(10);
        RxD = 1'b1;
        idle(80);
        check("glitch_busy_lo", 32'(busy),  32'd0);
        check("glitch_no_valid", 32'(valid), 32'd0);

        sb.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        sb.push_back('{d: 8'h22, pe: 1'b0, fe: 1'b0, ov: 1'b1});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        check("ovr_seen", 32'(sb.size()), 32'd0);
        ack_and_check("ovr");
        idle(20);
        sb.push_back('{d: 8'h33, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        ack_and_check("after_ovr");
        idle(20);

        sb.push_back('{d: 8'h33, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        RxD = 1'b0;
        idle(BIT_CLK);
        RxD = 1'b0;
        idle(BIT_CLK);
        RxD = 1'b1;
        idle(BIT_CLK / 2);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        idle(3);
        check("midrst_data",  32'(data),      32'd0);
        check("midrst_valid", 32'(valid),     32'd0);
        check("midrst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        RxD = 1'b1;
        rst = 1'b1;
        idle(30);
        sb.push_back('{d: 8'h7E, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, -1);
        idle(10);
        ack_and_check("post_rst");
        idle(20);

`ifdef RX_MAJORITY_EN
        sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 0);
        idle(10);
        ack_and_check("vote");
        idle(20);
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver_ovs.md
# uart_receiver_ovs

Parametrised UART receiver, successor to the fixed 8N1 receiver in Master_Control. It has an integrated oversampling tick generator, configurable frame format (data bits, parity, stop bits), start-bit glitch rejection and error/overrun reporting. It sits between the serial input pin and the command decoder. It presents each received character with a valid/ack handshake.

## Interface
- DATA_BITS, 8: data bits per frame, 5..8.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- OVERSAMPLE, 16: oversample ticks per bit, even, 8..32.
- CLK_DIV, 27: clk cycles per oversample tick, ≥2.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- RxD  in  1  serial input; asynchronous; idle high.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none. Sampled only in IDLE.
- data  out  DATA_BITS  last received character, LSB first on the line. Held until the next character completes.
- valid  out  1  high from character completion until data_ack.
- data_ack  in  1  consumer acknowledge; clears valid.
- parity_err  out  1  parity error of the character in data.
- frame_err  out  1  a stop bit was sampled low for the character in data.
- overrun  out  1  a new character completed while valid was still high.
- busy  out  1  high in every state except IDLE.

## Operation
- RxD passes through a 2-flop synchroniser (rx_s) before any use.
- Tick generator:
  - div counter runs 0..CLK_DIV-1 and emits tick on CLK_DIV-1.
  - The counter is cleared on the IDLE→START transition, so bit phase is aligned to the start edge.
- Sample counter sc counts ticks 0..OVERSAMPLE-1 within each bit.
  - The sample point is sc = OVERSAMPLE/2 (see Configuration).
- FSM states:
  - IDLE: on a falling edge of rx_s (previous 1, current 0), go to START with sc=0.
  - START: at the sample point, if the line is low go to DATA with bit index 0. If the line is high (glitch), go to IDLE with no outputs changed.
  - DATA: at each sample point, shift the sampled bit into bit position [index] of the shift register. After bit DATA_BITS-1, go to PARITY if parity is enabled, else to STOP.
  - PARITY: sample the parity bit. The error is computed as XOR of the data bits with the parity bit, inverted for odd parity (expected even: XOR==0; expected odd: XOR==1).
  - STOP: sample each stop bit. Any low sample sets the frame error. At the sample point of the last stop bit, complete the character and go to IDLE.
- Returning to IDLE mid-stop-bit allows a back-to-back start edge to be detected immediately.
- Completion happens in one clk:
  - data ← shift register.
  - parity_err and frame_err ← the computed values.
  - overrun ← valid & ~data_ack.
  - valid ← 1.
- overrun and both error flags hold until the next completion overwrites them.
- data_ack with valid low has no effect.
- Completion and data_ack in the same cycle: the completion wins, valid stays 1, overrun=0.
- Bits 7..DATA_BITS of any internal 8-bit view are zero. data is exactly DATA_BITS wide.

## Timing
- Reset values:
  - data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - FSM in IDLE, counters 0, synchroniser flops 1.
- Bit period is OVERSAMPLE×CLK_DIV clk cycles.
- The input synchroniser adds 2 clk of delay.
- valid rises 1 clk after the tick that is the last stop-bit sample point.
- valid falls in the clk after data_ack is sampled high.
- Reset asserted mid-frame aborts the frame immediately. No valid is produced, and the FSM returns to IDLE.
- A line held low (break) produces one character with frame_err=1. A new start requires a high→low edge.

## Configuration
- RX_MAJORITY_EN defined:
  - Each bit value is the 2-of-3 majority of samples at sc = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The decision is made at sc = OVERSAMPLE/2+1, so completion moves 1 tick later.
  - START glitch rejection also uses the vote.
- RX_MAJORITY_EN not defined: single sample at sc = OVERSAMPLE/2.

## Structure
- Package uart_rx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10).
- Sub-module uart_rx_tick_gen contains the CLK_DIV divider, with a sync clear input and a tick output.

## Test plan
Bench uses CLK_DIV=4, OVERSAMPLE=16 (bit = 64 clk), DATA_BITS=8.
- 8N1, send 0xA5 → valid=1, data=0xA5, parity_err=0, frame_err=0, overrun=0. data_ack clears valid next clk.
- RxD low for 20 clk, then high → busy pulses, no valid, FSM back in IDLE.
- 8E1, send 0x03 with parity bit 1 → data=0x03, parity_err=1. Repeat with parity bit 0 → parity_err=0.
- 8N1, stop bit driven 0 → valid=1, frame_err=1. Next clean frame 0x5A → frame_err=0.
- Send 0x11 then 0x22 back-to-back with no ack → data=0x22, overrun=1. Ack, then send 0x33 → overrun=0.
- rst asserted in the middle of the DATA state → all outputs at reset values. A following clean 0x7E is received correctly.
- Each scenario runs both with and without RX_MAJORITY_EN.
- Under RX_MAJORITY_EN, a single-clk high glitch at the centre of a 0 data bit → bit still read as 0.
